// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier controller: FSM state encoding and datapath strobe bundle.
// Independent of operand width so every width instance shares one package.
package mult_pkg;

    localparam int MULT_WIDTH_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADB = 3'd1,
        ST_CLEAR = 3'd2,
        ST_READY = 3'd3,
        ST_STEP  = 3'd4,
        ST_FINAL = 3'd5,
        ST_HOLD  = 3'd6,
        ST_REARM = 3'd7
    } state_e;

    typedef struct packed {
        logic shift;
        logic add;
        logic sub;
        logic clr;
        logic loadb;
    } strobe_t;

    localparam strobe_t STROBE_NONE = '0;

endpackage

// File: rtl/mult_step_counter.sv
// Loadable down-counter sequencing the add/shift steps; zero_o flags the last STEP cycle.
// Loads WIDTH-2 so that WIDTH-1 STEP cycles elapse before zero is seen.
module mult_step_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The decrement past zero on the STEP exit edge wraps to all-ones; that value is never consumed.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-add multiplier: load, clear, WIDTH add/shift steps, run-release rearm.
// Optional signed correction in the final step is built only with MULT_SEQ_CTRL_SIGNED_EN defined.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    input  logic signed_mode_i,
    input  logic m_val_i,
    output logic shift_o,
    output logic add_o,
    output logic sub_o,
    output logic clr_o,
    output logic loadb_o,
    output logic busy_o,
    output logic done_o
);

    state_e  state_q, state_d;
    strobe_t strobe;
    logic    busy, done;
    logic    cnt_zero, cnt_load, cnt_en;
    logic    run_accept;
    logic    final_sub;

    assign run_accept = (state_q == ST_READY) && run_i;
    assign cnt_load   = run_accept;
    assign cnt_en     = (state_q == ST_STEP);

    mult_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .zero_o (cnt_zero)
    );

`ifdef MULT_SEQ_CTRL_SIGNED_EN
    logic signed_q, signed_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            signed_q <= 1'b0;
        end else begin
            signed_q <= signed_d;
        end
    end

    // Mode is frozen at Run acceptance so mid-multiply switch changes cannot corrupt the product.
    always_comb begin
        signed_d = signed_q;
        if (run_accept) begin
            signed_d = signed_mode_i;
        end
    end

    assign final_sub = signed_q & m_val_i;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode_i;
    assign final_sub          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run has priority over Load wherever both are honoured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_i) state_d = ST_LOADB;
            ST_LOADB: state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_READY;
            ST_READY: begin
                if (run_i) begin
                    state_d = ST_STEP;
                end else if (load_i) begin
                    state_d = ST_LOADB;
                end
            end
            ST_STEP:  if (cnt_zero) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_HOLD;
            ST_HOLD:  if (!run_i) state_d = ST_REARM;
            ST_REARM: begin
                if (run_i) begin
                    state_d = ST_CLEAR;
                end else if (load_i) begin
                    state_d = ST_LOADB;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Add/Sub are Mealy on m_val_i; everything else decodes from state alone.
    always_comb begin
        strobe = STROBE_NONE;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_LOADB: strobe.loadb = 1'b1;
            ST_CLEAR: strobe.clr   = 1'b1;
            ST_STEP: begin
                strobe.shift = 1'b1;
                strobe.add   = m_val_i;
                busy         = 1'b1;
            end
            ST_FINAL: begin
                strobe.shift = 1'b1;
                busy         = 1'b1;
                if (final_sub) begin
                    strobe.sub = 1'b1;
                end else begin
                    strobe.add = m_val_i;
                end
            end
            ST_HOLD,
            ST_REARM: done = 1'b1;
            default: begin
                strobe = STROBE_NONE;
                busy   = 1'b0;
                done   = 1'b0;
            end
        endcase
    end

    assign shift_o = strobe.shift;
    assign add_o   = strobe.add;
    assign sub_o   = strobe.sub;
    assign clr_o   = strobe.clr;
    assign loadb_o = strobe.loadb;
    assign busy_o  = busy;
    assign done_o  = done;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl at WIDTH=8 and WIDTH=4 with a per-cycle expected-output scoreboard.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic load8, run8, sm8, m8;
    logic load4, run4, sm4, m4;
    logic sh8, ad8, sb8, cl8, lb8, bz8, dn8;
    logic sh4, ad4, sb4, cl4, lb4, bz4, dn4;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load8), .run_i(run8),
        .signed_mode_i(sm8), .m_val_i(m8),
        .shift_o(sh8), .add_o(ad8), .sub_o(sb8), .clr_o(cl8), .loadb_o(lb8),
        .busy_o(bz8), .done_o(dn8)
    );

    mult_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load4), .run_i(run4),
        .signed_mode_i(sm4), .m_val_i(m4),
        .shift_o(sh4), .add_o(ad4), .sub_o(sb4), .clr_o(cl4), .loadb_o(lb4),
        .busy_o(bz4), .done_o(dn4)
    );

`ifdef MULT_SEQ_CTRL_SIGNED_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif

    // Output vector layout: {loadb, clr, shift, add, sub, busy, done}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LOADB = 7'b1000000;
    localparam logic [6:0] O_CLR   = 7'b0100000;
    localparam logic [6:0] O_DONE  = 7'b0000001;

    int nvec = 0;
    int nmis = 0;
    logic [6:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] pat;

    function automatic logic [6:0] stepv(input logic m);
        return {3'b001, m, 3'b010};
    endfunction

    function automatic logic [6:0] finv(input logic m, input logic s);
        return (s && m) ? 7'b0010110 : stepv(m);
    endfunction

    function automatic logic [6:0] obs(input bit sel);
        return sel ? {lb4, cl4, sh4, ad4, sb4, bz4, dn4}
                   : {lb8, cl8, sh8, ad8, sb8, bz8, dn8};
    endfunction

    task automatic check(input bit sel);
        logic [6:0] e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = obs(sel);
        nvec++;
        assert (o === e) else begin
            nmis++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
    endtask

    task automatic expect_now(input bit sel, input logic [6:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        check(sel);
    endtask

    task automatic cyc(input bit sel, input logic l, input logic r, input logic s,
                       input logic m, input logic [6:0] e, input string t);
        @(negedge clk);
        if (sel) begin
            load4 = l; run4 = r; sm4 = s; m4 = m;
        end else begin
            load8 = l; run8 = r; sm8 = s; m8 = m;
        end
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        check(sel);
    endtask

    initial begin
        rst_n = 1'b0;
        load8 = 0; run8 = 0; sm8 = 0; m8 = 0;
        load4 = 0; run4 = 0; sm4 = 0; m4 = 0;

        cyc(0, 0, 0, 0, 1, O_IDLE, "reset8");
        cyc(1, 0, 0, 0, 1, O_IDLE, "reset4");
        rst_n = 1'b1;

        // Unsigned multiply, M_val=1 throughout, Run held long after Done
        cyc(0, 1, 0, 0, 1, O_IDLE, "idle_load");
        cyc(0, 0, 1, 0, 1, O_LOADB, "loadb");
        cyc(0, 0, 1, 0, 1, O_CLR, "clr");
        cyc(0, 0, 1, 0, 1, O_IDLE, "ready_run");
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 1, stepv(1'b1), "step_u");
        cyc(0, 0, 1, 0, 1, finv(1'b1, 1'b0), "final_u");
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 1, O_DONE, "hold_run_high");
        cyc(0, 0, 0, 0, 1, O_DONE, "hold_run_fall");
        cyc(0, 0, 0, 0, 1, O_DONE, "rearm");
        cyc(0, 0, 0, 0, 1, O_DONE, "rearm_wait");
        cyc(0, 0, 1, 0, 1, O_DONE, "rearm_run");
        cyc(0, 0, 1, 0, 1, O_CLR, "clr_no_loadb");

        // Signed mode latched at acceptance; Load and Signed_mode toggled mid-multiply
        cyc(0, 0, 1, 1, 0, O_IDLE, "ready_signed");
        pat = 8'b0101_1011;
        for (int i = 0; i < 7; i++)
            cyc(0, logic'(i % 2), 1, 0, pat[i], stepv(pat[i]), "step_pat");
        cyc(0, 0, 1, 0, 1, finv(1'b1, SGN), "final_signed");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, O_DONE, "hold_ignore_load");
        cyc(0, 0, 0, 0, 1, O_DONE, "hold_to_rearm");
        cyc(0, 1, 0, 0, 1, O_DONE, "rearm_load");
        cyc(0, 0, 0, 0, 1, O_LOADB, "reload");
        cyc(0, 0, 0, 0, 1, O_CLR, "reclr");

        // Load and Run together in READY: Run wins; mode latched unsigned
        cyc(0, 1, 1, 0, 1, O_IDLE, "ready_both");
        cyc(0, 1, 1, 1, 0, stepv(1'b0), "step_load_ign");
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 1, stepv(1'b1), "step_m1");
        cyc(0, 0, 1, 1, 1, finv(1'b1, 1'b0), "final_latched_u");
        cyc(0, 0, 1, 1, 1, O_DONE, "hold2");

        // Reset asserted during the third STEP cycle
        cyc(0, 0, 0, 0, 1, O_DONE, "hold2_fall");
        cyc(0, 0, 1, 0, 1, O_DONE, "rearm_run2");
        cyc(0, 0, 1, 0, 1, O_CLR, "clr3");
        cyc(0, 0, 1, 0, 1, O_IDLE, "ready3");
        cyc(0, 0, 1, 0, 1, stepv(1'b1), "step3_1");
        cyc(0, 0, 1, 0, 1, stepv(1'b1), "step3_2");
        cyc(0, 0, 1, 0, 1, stepv(1'b1), "step3_3");
        rst_n = 1'b0;
        #1;
        expect_now(0, O_IDLE, "rst_async");
        @(negedge clk);
        #1;
        expect_now(0, O_IDLE, "rst_held");
        rst_n = 1'b1;
        cyc(0, 0, 1, 0, 1, O_IDLE, "post_rst_idle_run");
        cyc(0, 1, 0, 0, 1, O_IDLE, "post_rst_idle");
        cyc(0, 0, 0, 0, 1, O_LOADB, "post_rst_loadb");

        // WIDTH=4: four Shift cycles, Done five edges after acceptance
        cyc(1, 1, 0, 0, 0, O_IDLE, "w4_idle");
        cyc(1, 0, 1, 0, 0, O_LOADB, "w4_loadb");
        cyc(1, 0, 1, 0, 0, O_CLR, "w4_clr");
        cyc(1, 0, 1, 0, 0, O_IDLE, "w4_ready");
        cyc(1, 0, 1, 0, 1, stepv(1'b1), "w4_step1");
        cyc(1, 0, 1, 0, 0, stepv(1'b0), "w4_step2");
        cyc(1, 0, 1, 0, 1, stepv(1'b1), "w4_step3");
        cyc(1, 0, 1, 0, 0, finv(1'b0, 1'b0), "w4_final");
        cyc(1, 0, 1, 0, 0, O_DONE, "w4_done");
        cyc(1, 0, 0, 0, 0, O_DONE, "w4_hold_fall");
        cyc(1, 0, 0, 0, 0, O_DONE, "w4_rearm");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
